// File: rtl/datamem_pkg.sv
// Shared definitions for the traced data memory.
//   LEN_*        : store/load length codes (length minus 1)
//   state_t      : controller state (CLEAR sequencer / READY for traffic)
//   trace_rec_t  : one write-trace record {stamp, pc, addr, data}
//   merge_word   : overlay lanes off..off+len of a store onto an old word
//   load_extend  : right-justify a sub-word load and sign/zero-extend it
package datamem_pkg;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_T = 2'd2;
    localparam logic [1:0] LEN_W = 2'd3;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] stamp;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } trace_rec_t;

    function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                               input logic [31:0] wd,
                                               input logic [1:0]  off,
                                               input logic [1:0]  len);
        logic [31:0] r;
        logic [2:0]  lo;
        logic [2:0]  hi;
        r  = old_w;
        lo = {1'b0, off};
        hi = lo + {1'b0, len};
        for (int k = 0; k < 4; k++) begin
            if (3'(k) >= lo && 3'(k) <= hi) begin
                r[8*k +: 8] = wd[8*k +: 8];
            end
        end
        return r;
    endfunction

    // Bytes shifted in from above the word are zero, so a load that runs off
    // the end of the word returns only the in-word bytes, then extends.
    function automatic logic [31:0] load_extend(input logic [31:0] w,
                                                input logic [1:0]  off,
                                                input logic [1:0]  len,
                                                input logic        sgn);
        logic [31:0] sh;
        logic [31:0] r;
        sh = w >> {off, 3'b000};
        case (len)
            LEN_B:   r = {{24{sgn & sh[7]}},  sh[7:0]};
            LEN_H:   r = {{16{sgn & sh[15]}}, sh[15:0]};
            LEN_T:   r = {{8{sgn & sh[23]}},  sh[23:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/datamem_traced_trace_fifo.sv
// Circular FIFO holding write-trace records.
//   clk, reset : clock, async active-low reset (pointers/count only)
//   push/wdata : enqueue a record; caller only pushes when !full or popping
//   pop/rdata  : rdata is the head record (combinational), pop advances it
//   full/empty : occupancy flags
// Push and pop in the same cycle on a full FIFO is safe: the head slot is
// read combinationally before the edge that overwrites it.
module datamem_traced_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  store [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;

    assign rdata = store[head];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) store[tail] <= wdata;
    end

endmodule

// File: rtl/datamem_traced.sv
// Word-organised data memory with byte-lane stores, extended sub-word loads,
// misalignment flag, post-reset clear sequencer and a delayed write trace.
//   clk, reset          : clock, async active-low reset
//   A, WD, WE, WLen, PC : store request (lane-positioned data, PC for trace)
//   RE, RLen, RSigned   : load request; RD is combinational load data
//   busy                : clear sequence running, traffic ignored
//   misalign            : current store/load crosses a word boundary
//   trace_*             : head of the write-trace FIFO, valid once aged
//   trace_overflow      : sticky, a record was dropped on a full FIFO
//
// state | meaning
// ------+----------------------------------------------------------
// CLEAR | zeroing word clr_idx each cycle, stores/loads suppressed
// READY | normal store/load operation
module datamem_traced
    import datamem_pkg::*;
#(
    parameter int ADDR_BITS      = 10,
    parameter int TRACE_DEPTH    = 16,
    parameter int TRACE_DELAY    = 3,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    input  logic        WE,
    input  logic [1:0]  WLen,
    input  logic        RE,
    input  logic [1:0]  RLen,
    input  logic        RSigned,
    input  logic [31:0] PC,
    output logic [31:0] RD,
    output logic        busy,
    output logic        misalign,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic        trace_overflow
);

    localparam int MAXN = 2**ADDR_BITS;
    localparam int RECW = $bits(trace_rec_t);

    state_t                 state_q;
    state_t                 state_d;
    logic [ADDR_BITS-1:0]   clr_idx;
    logic [31:0]            cnt;
    logic [31:0]            mem [MAXN];

    logic [ADDR_BITS-1:0]   sa;
    logic [1:0]             off;
    logic                   is_ready;
    logic                   w_cross;
    logic                   r_cross;
    logic                   store_ok;
    logic [31:0]            cur_word;
    logic [31:0]            merged;

    trace_rec_t             rec_in;
    trace_rec_t             rec_head;
    logic [RECW-1:0]        head_bits;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   drop;
    logic [31:0]            age;

    assign sa       = A[ADDR_BITS+1:2];
    assign off      = A[1:0];
    assign is_ready = (state_q == READY);
    assign busy     = !is_ready;

    assign w_cross  = ({1'b0, off} + {1'b0, WLen}) > 3'd3;
    assign r_cross  = ({1'b0, off} + {1'b0, RLen}) > 3'd3;
    assign store_ok = is_ready && WE && !w_cross;
    assign misalign = is_ready && ((WE && w_cross) || (RE && r_cross));

    // Combinational read: a same-word store this cycle is not yet visible.
    assign cur_word = mem[sa];
    assign merged   = merge_word(cur_word, WD, off, WLen);
    assign RD       = is_ready ? load_extend(cur_word, off, RLen, RSigned) : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (clr_idx == ADDR_BITS'(MAXN-1)) state_d = READY;
            default: state_d = READY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_idx        <= '0;
            cnt            <= '0;
            trace_overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt     <= cnt + 1'b1;
            if (state_q == CLEAR) clr_idx <= clr_idx + 1'b1;
            if (drop) trace_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (store_ok) begin
            mem[sa] <= merged;
        end
    end

    always_comb begin
        rec_in       = '0;
        rec_in.stamp = cnt;
        rec_in.pc    = PC;
        rec_in.addr  = A;
        rec_in.data  = merged;
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign fifo_pop  = trace_valid && trace_ready;
    assign fifo_push = store_ok && (!fifo_full || fifo_pop);
    assign drop      = store_ok && fifo_full && !fifo_pop;

    datamem_traced_trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .W     (RECW)
    ) u_trace_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (rec_in),
        .pop   (fifo_pop),
        .rdata (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rec_head    = trace_rec_t'(head_bits);
    // Modular difference keeps ageing correct across counter wrap.
    assign age         = cnt - rec_head.stamp;
    assign trace_valid = !fifo_empty && (age >= 32'(TRACE_DELAY));
    assign trace_pc    = fifo_empty ? '0 : rec_head.pc;
    assign trace_addr  = fifo_empty ? '0 : rec_head.addr;
    assign trace_data  = fifo_empty ? '0 : rec_head.data;

endmodule

// File: tb/tb_datamem_traced.sv
module tb_datamem_traced;

    localparam int AB    = 4;
    localparam int MAXN  = 16;
    localparam int TD    = 4;
    localparam int TDLY  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] A = '0, WD = '0, PC = '0;
    logic        WE = 1'b0, RE = 1'b0, RSigned = 1'b0, trace_ready = 1'b0;
    logic [1:0]  WLen = '0, RLen = '0;
    logic [31:0] RD, trace_pc, trace_addr, trace_data;
    logic        busy, misalign, trace_valid, trace_overflow;

    always #5 clk = ~clk;

    datamem_traced #(
        .ADDR_BITS      (AB),
        .TRACE_DEPTH    (TD),
        .TRACE_DELAY    (TDLY),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .A              (A),
        .WD             (WD),
        .WE             (WE),
        .WLen           (WLen),
        .RE             (RE),
        .RLen           (RLen),
        .RSigned        (RSigned),
        .PC             (PC),
        .RD             (RD),
        .busy           (busy),
        .misalign       (misalign),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_pc       (trace_pc),
        .trace_addr     (trace_addr),
        .trace_data     (trace_data),
        .trace_overflow (trace_overflow)
    );

    // Reference model: byte array, queue of trace records, cycle count.
    typedef struct {
        logic [31:0] stamp;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    logic [7:0]  mb [4*MAXN];
    rec_t        q[$];
    logic [31:0] mcyc;
    int          clear_left;
    bit          movf;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] word_of(input int wi);
        return {mb[4*wi+3], mb[4*wi+2], mb[4*wi+1], mb[4*wi]};
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] rl, input logic sg);
        logic [31:0] v, mask;
        int n, o;
        o = int'(a[1:0]);
        n = 8 * (int'(rl) + 1);
        v = word_of(int'(a[AB+1:2])) >> (8 * o);
        mask = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
        v = v & mask;
        if (sg && n < 32 && v[n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit model_vis();
        return (q.size() > 0) && ((mcyc - q[0].stamp) >= 32'(TDLY));
    endfunction

    task automatic check_outputs();
        bit mbusy;
        bit exp_mis;
        mbusy = (clear_left > 0);
        exp_mis = !mbusy && ((WE && (int'(A[1:0]) + int'(WLen) > 3)) ||
                             (RE && (int'(A[1:0]) + int'(RLen) > 3)));
        chk("busy", 32'(busy), 32'(mbusy));
        chk("misalign", 32'(misalign), 32'(exp_mis));
        chk("rd", RD, mbusy ? 32'h0 : exp_load(A, RLen, RSigned));
        chk("trace_valid", 32'(trace_valid), 32'(model_vis()));
        chk("trace_pc", trace_pc, (q.size() > 0) ? q[0].pc : 32'h0);
        chk("trace_addr", trace_addr, (q.size() > 0) ? q[0].addr : 32'h0);
        chk("trace_data", trace_data, (q.size() > 0) ? q[0].data : 32'h0);
        chk("trace_overflow", 32'(trace_overflow), 32'(movf));
    endtask

    task automatic model_edge();
        bit pop, push, full_before;
        int o, wi;
        rec_t r;
        pop = model_vis() && trace_ready;
        push = (clear_left == 0) && WE && (int'(A[1:0]) + int'(WLen) <= 3);
        full_before = (q.size() == TD);
        if (push) begin
            o = int'(A[1:0]);
            wi = int'(A[AB+1:2]);
            for (int k = o; k <= o + int'(WLen); k++) mb[4*wi+k] = WD[8*k +: 8];
        end
        if (pop) void'(q.pop_front());
        if (push) begin
            if (full_before && !pop) movf = 1'b1;
            else begin
                r.stamp = mcyc;
                r.pc = PC;
                r.addr = A;
                r.data = word_of(int'(A[AB+1:2]));
                q.push_back(r);
            end
        end
        mcyc = mcyc + 32'd1;
        if (clear_left > 0) clear_left--;
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        WE = 1'b0;
        RE = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        q.delete();
        movf = 1'b0;
        mcyc = '0;
        clear_left = MAXN;
        for (int i = 0; i < 4*MAXN; i++) mb[i] = 8'h00;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_valid", 32'(trace_valid), 32'd0);
        chk("rst_ovf", 32'(trace_overflow), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] wl,
                         input logic [31:0] pc);
        A = a; WD = wd; WLen = wl; PC = pc; WE = 1'b1; RE = 1'b0;
        step();
        WE = 1'b0;
    endtask

    task automatic load_exp(input string tag, input logic [31:0] a, input logic [1:0] rl,
                            input logic sg, input logic [31:0] exp);
        A = a; RLen = rl; RSigned = sg; RE = 1'b1; WE = 1'b0;
        #1;
        chk(tag, RD, exp);
        step();
        RE = 1'b0;
    endtask

    task automatic wait_clear_counted(input string tag);
        int n;
        n = 0;
        while (busy && n < 40) begin
            n++;
            step();
        end
        chk(tag, 32'(n), 32'(MAXN));
    endtask

    initial begin
        int got;
        logic [31:0] exp_pc;

        // Clear sequence: stores attempted while busy must be ignored.
        do_reset();
        trace_ready = 1'b1;
        A = 32'h3C; WD = 32'hDEADBEEF; WLen = 2'd3; PC = 32'h1; WE = 1'b1;
        wait_clear_counted("clear_len");
        WE = 1'b0;
        load_exp("ld_3c_cleared", 32'h3C, 2'd3, 1'b0, 32'h0);
        store(32'h3C, 32'hCAFEF00D, 2'd3, 32'h2);
        load_exp("ld_3c", 32'h3C, 2'd3, 1'b0, 32'hCAFEF00D);

        // Byte merge and extended loads.
        store(32'h10, 32'h11223344, 2'd3, 32'h10);
        store(32'h11, 32'h0000AA00, 2'd0, 32'h11);
        load_exp("ld_word", 32'h10, 2'd3, 1'b0, 32'h1122AA44);
        load_exp("ld_sbyte", 32'h11, 2'd0, 1'b1, 32'hFFFFFFAA);
        load_exp("ld_ubyte", 32'h11, 2'd0, 1'b0, 32'h000000AA);

        // Misaligned store is dropped; a three-byte store at offset 1 is legal.
        A = 32'h13; WD = 32'h99887766; WLen = 2'd1; PC = 32'h12; WE = 1'b1;
        #1;
        chk("mis_store", 32'(misalign), 32'd1);
        step();
        WE = 1'b0;
        load_exp("ld_after_mis", 32'h10, 2'd3, 1'b0, 32'h1122AA44);
        A = 32'h11; WLen = 2'd2; WE = 1'b1;
        #1;
        chk("legal_t", 32'(misalign), 32'd0);
        step();
        WE = 1'b0;
        load_exp("ld_after_t", 32'h10, 2'd3, 1'b0, 32'h99887744);

        // Trace latency: record becomes visible exactly TDLY cycles after commit.
        idle(8);
        store(32'h20, 32'h55667788, 2'd3, 32'h3000);
        got = 0;
        for (int i = 1; i <= 6 && got == 0; i++) begin
            if (trace_valid) got = i;
            else step();
        end
        chk("trace_lat", 32'(got), 32'(TDLY));
        chk("trace_lat_pc", trace_pc, 32'h3000);
        idle(2);

        // Overflow with the consumer stalled.
        do_reset();
        idle(MAXN);
        trace_ready = 1'b0;
        for (int i = 0; i < 5; i++) store(32'(4*i), $urandom, 2'd3, 32'h100 + 32'(i));
        idle(4);
        chk("ovf_set", 32'(trace_overflow), 32'd1);
        trace_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'h100 + 32'(i);
            got = 0;
            for (int j = 0; j < 10 && got == 0; j++) begin
                if (trace_valid) got = 1;
                else step();
            end
            chk("drain_seen", 32'(got), 32'd1);
            chk("drain_pc", trace_pc, exp_pc);
            step();
        end
        idle(2);
        chk("ovf_sticky", 32'(trace_overflow), 32'd1);

        // Full FIFO with push and pop in the same cycle: nothing dropped.
        do_reset();
        idle(MAXN);
        trace_ready = 1'b0;
        for (int i = 0; i < 4; i++) store(32'(4*i), $urandom, 2'd3, 32'h200 + 32'(i));
        idle(4);
        trace_ready = 1'b1;
        store(32'h30, 32'h0BADF00D, 2'd3, 32'h204);
        chk("full_pushpop_ovf", 32'(trace_overflow), 32'd0);
        idle(12);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            A = {$urandom_range(0, 255), 24'h0} | 32'($urandom_range(0, 63));
            WD = $urandom;
            PC = $urandom;
            WLen = 2'($urandom_range(0, 3));
            RLen = 2'($urandom_range(0, 3));
            RSigned = 1'($urandom_range(0, 1));
            WE = ($urandom_range(0, 99) < 45);
            RE = ($urandom_range(0, 99) < 50);
            trace_ready = ($urandom_range(0, 99) < 60);
            step();
        end
        idle(2);

        // Reset in the middle of the clear sequence restarts it from zero.
        do_reset();
        idle(5);
        do_reset();
        wait_clear_counted("clear_restart_len");
        load_exp("ld_after_restart", 32'h10, 2'd3, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/datamem_traced.md
Name: datamem_traced

Overview:
- Parametrised successor to the single-cycle data memory.
- Word-organised RAM with byte-lane stores (1–4 bytes, lane-positioned data) and sign/zero-extended sub-word loads.
- Misalignment detection, plus a post-reset clear sequencer replacing the bulk array clear.
- Delayed write-trace FIFO with valid/ready output so the bench or debug logic consumes store records a fixed number of cycles after commit.

Parameters:
ADDR_BITS, 10, word-address bits; depth MAXN = 2**ADDR_BITS words
TRACE_DEPTH, 16, trace FIFO entries (power of 2, >=2)
TRACE_DELAY, 3, minimum cycles between store commit and trace record becoming visible (0..255)
CLEAR_ON_RESET, 1, 1 = zero every word after reset via sequencer; 0 = contents untouched, READY immediately

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  reset, asynchronous, active-low
A  in  32  byte address; word index A[ADDR_BITS+1:2], byte offset A[1:0]
WD  in  32  store data, lane-positioned (byte k of word on WD[8k+7:8k])
WE  in  1  store request
WLen  in  2  store length minus 1 (0=byte, 1=half, 2=three bytes, 3=word)
RE  in  1  load request (qualifies misalign only)
RLen  in  2  load length minus 1, same encoding
RSigned  in  1  1 = sign-extend load, 0 = zero-extend
PC  in  32  PC of the store, recorded in trace
RD  out  32  load data, right-justified and extended
busy  out  1  clear sequence in progress
misalign  out  1  current request crosses a word boundary
trace_valid  out  1  head record aged and presentable
trace_ready  in  1  consumer accepts head record
trace_pc  out  32  PC of head record
trace_addr  out  32  A of head record
trace_data  out  32  full word after the store merge
trace_overflow  out  1  sticky: a store record was dropped because FIFO was full

Behaviour:
- Reset (reset==0, async): state <= CLEAR if CLEAR_ON_RESET else READY; clr_idx=0; FIFO head/tail/count=0; cycle counter cnt=0; trace_overflow=0. busy=CLEAR_ON_RESET, trace_valid=0. Array contents not reset asynchronously.
- CLEAR: each cycle writes 0 to word clr_idx, clr_idx++. After writing word MAXN-1, goes to READY next edge; busy falls the same edge. Duration exactly MAXN cycles. WE ignored, no trace pushes, RD forced 0, misalign forced 0.
- Reset asserted mid-CLEAR restarts at clr_idx=0. Reset mid-trace discards all records.
- READY store:
  - legal iff WE && (A[1:0]+WLen)<=3.
  - Bytes A[1:0]..A[1:0]+WLen of word sa take the same lanes of WD; other bytes unchanged. Commit on the rising edge.
  - Illegal: misalign=1 combinationally, no write, no trace push.
- misalign = (WE && A[1:0]+WLen>3) || (RE && A[1:0]+RLen>3), purely combinational.
- Load (combinational, READY): word=mem[sa]; shift right by 8*A[1:0]; keep 8*(RLen+1) bits; extend per RSigned. Misaligned load returns the in-word bytes available, extended the same way.
- Read-during-write on the same word returns the pre-write value in that cycle.
- cnt: free-running 32-bit counter, increments every cycle out of reset, wraps. Age = cnt - stamp, modulo 2^32.
- Trace push on every legal store: {stamp=cnt, PC, A, merged word}.
- Full and no pop in the same cycle: record dropped, trace_overflow<=1 (sticky until reset).
- trace_valid = count>0 && age(head)>=TRACE_DELAY. trace_* outputs show head fields; zero when empty.
- Pop when trace_valid && trace_ready.
- Simultaneous push and pop: both happen, count unchanged. This applies when full too; no drop.
- TRACE_DELAY=0: record visible the cycle after commit (registered FIFO, no bypass).
- Pointers wrap modulo TRACE_DEPTH.

Decomposition:
- Package datamem_pkg: length encodings (LEN_B, LEN_H, LEN_T, LEN_W), state enum {CLEAR, READY}, trace record struct {stamp, pc, addr, data}, byte-merge and extend functions.
- Sub-module trace_fifo: parametrised on depth and record width; push/pop/full/empty/count. Ageing logic stays in the parent.

Test Plan:
- CLEAR_ON_RESET=1, ADDR_BITS=4: release reset -> busy=1 for exactly 16 cycles, then 0. Store word to 0x3C accepted only after busy falls.
- Store word 0x11223344 @0x10, then byte WD=0x0000AA00 WLen=0 @0x11 -> load word @0x10 = 0x1122AA44. RLen=0 RSigned=1 @0x11 -> 0xFFFFFFAA. RSigned=0 -> 0x000000AA.
- Half store @0x13 -> misalign=1, memory @0x10 unchanged, no trace push. WLen=2 @0x11 -> legal.
- TRACE_DELAY=3, trace_ready=1: store PC=0x3000 @0x20 at cycle t -> trace_valid first high at t+3 with trace_pc=0x3000, trace_addr=0x20, trace_data=merged word.
- TRACE_DEPTH=4, trace_ready=0: 5 legal stores -> count=4, trace_overflow=1. Raise ready -> first 4 records in order. Overflow stays 1 until reset.
- Full FIFO with push and pop in the same cycle -> count stays 4, no overflow. Pull reset low mid-CLEAR -> busy restarts full 2**ADDR_BITS cycles.
